wb8_master_arbiter: RTL and testbench



---
 rtl/wb8_master_arbiter.sv | 128 ++++++++++++
 tb/tb_wb8_master_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb8_master_arbiter.sv
// Two-master round-robin arbiter for the 8-bit Wishbone bus, cycle-locked grants.
// Optional slave watchdog enabled by defining ARBITER_TIMEOUT_EN.
module wb8_master_arbiter #(
  parameter int unsigned TIMEOUTBITS = 8
) (
  input  logic        I_wb_clk,
  input  logic        I_reset,
  input  logic        I_m0_cyc,
  input  logic        I_m0_stb,
  input  logic        I_m0_we,
  input  logic [31:0] I_m0_adr,
  input  logic [7:0]  I_m0_dat,
  output logic [7:0]  O_m0_dat,
  output logic        O_m0_ack,
  output logic        O_m0_stall,
  input  logic        I_m1_cyc,
  input  logic        I_m1_stb,
  input  logic        I_m1_we,
  input  logic [31:0] I_m1_adr,
  input  logic [7:0]  I_m1_dat,
  output logic [7:0]  O_m1_dat,
  output logic        O_m1_ack,
  output logic        O_m1_stall,
  output logic        O_wb_stb,
  output logic        O_wb_we,
  output logic [31:0] O_wb_adr,
  output logic [7:0]  O_wb_dat,
  input  logic [7:0]  I_wb_dat,
  input  logic        I_wb_ack,
  input  logic        I_wb_stall,
  output logic [1:0]  O_grant,
  output logic        O_err
);

  // Encoding doubles as the one-hot {m1, m0} grant vector.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;
  logic   g0, g1;
  logic   wd_fire;

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (I_m0_cyc && I_m1_cyc) state_nxt = last ? GRANT0 : GRANT1;
        else if (I_m0_cyc)        state_nxt = GRANT0;
        else if (I_m1_cyc)        state_nxt = GRANT1;
      end
      GRANT0: begin
        if (!I_m0_cyc) begin
          last_nxt  = 1'b0;
          state_nxt = I_m1_cyc ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        if (!I_m1_cyc) begin
          last_nxt  = 1'b1;
          state_nxt = I_m0_cyc ? GRANT0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign g0      = (state == GRANT0);
  assign g1      = (state == GRANT1);
  assign O_grant = state;

  assign O_wb_stb = (g0 & I_m0_stb) | (g1 & I_m1_stb);
  assign O_wb_we  = g1 ? I_m1_we  : I_m0_we;
  assign O_wb_adr = g1 ? I_m1_adr : I_m0_adr;
  assign O_wb_dat = g1 ? I_m1_dat : I_m0_dat;

  assign O_m0_dat   = wd_fire ? 8'hFF : I_wb_dat;
  assign O_m1_dat   = wd_fire ? 8'hFF : I_wb_dat;
  assign O_m0_ack   = g0 & (I_wb_ack | wd_fire);
  assign O_m1_ack   = g1 & (I_wb_ack | wd_fire);
  assign O_m0_stall = g0 ? I_wb_stall : 1'b1;
  assign O_m1_stall = g1 ? I_wb_stall : 1'b1;

`ifdef ARBITER_TIMEOUT_EN
  // Fires in the strobe cycle that would carry the count to all-ones,
  // i.e. on the (2^TIMEOUTBITS-1)th consecutive unacknowledged strobe cycle.
  localparam logic [TIMEOUTBITS-1:0] WD_LAST = {{(TIMEOUTBITS-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUTBITS-1:0] WD_ONE  = {{(TIMEOUTBITS-1){1'b0}}, 1'b1};

  logic [TIMEOUTBITS-1:0] wd_cnt;
  logic                   err_q;

  assign wd_fire = O_wb_stb & ~I_wb_ack & (wd_cnt == WD_LAST);

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (I_wb_ack || wd_fire || !O_wb_stb || (state_nxt != state)) wd_cnt <= '0;
      else                                                          wd_cnt <= wd_cnt + WD_ONE;
      if (wd_fire) err_q <= 1'b1;
    end
  end

  assign O_err = err_q;
`else
  logic [31:0] unused_timeoutbits;
  assign unused_timeoutbits = TIMEOUTBITS;
  assign wd_fire = 1'b0;
  assign O_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb8_master_arbiter.sv
// Self-checking bench for wb8_master_arbiter: directed scenarios plus random traffic
// compared against a cycle-level ownership/watchdog model.
module tb_wb8_master_arbiter;

  localparam int unsigned TO_BITS = 4;
  localparam int LIMIT = (1 << TO_BITS) - 1;
`ifdef ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m0_adr = '0, m1_adr = '0;
  logic [7:0]  m0_dat = '0, m1_dat = '0, wb_dat_in = '0;
  logic        wb_ack = 0, wb_stall = 0;
  logic [7:0]  o_m0_dat, o_m1_dat, o_wb_dat;
  logic        o_m0_ack, o_m1_ack, o_m0_stall, o_m1_stall, o_wb_stb, o_wb_we, o_err;
  logic [31:0] o_wb_adr;
  logic [1:0]  o_grant;

  wb8_master_arbiter #(.TIMEOUTBITS(TO_BITS)) dut (
    .I_wb_clk(clk), .I_reset(rst),
    .I_m0_cyc(m0_cyc), .I_m0_stb(m0_stb), .I_m0_we(m0_we), .I_m0_adr(m0_adr),
    .I_m0_dat(m0_dat), .O_m0_dat(o_m0_dat), .O_m0_ack(o_m0_ack), .O_m0_stall(o_m0_stall),
    .I_m1_cyc(m1_cyc), .I_m1_stb(m1_stb), .I_m1_we(m1_we), .I_m1_adr(m1_adr),
    .I_m1_dat(m1_dat), .O_m1_dat(o_m1_dat), .O_m1_ack(o_m1_ack), .O_m1_stall(o_m1_stall),
    .O_wb_stb(o_wb_stb), .O_wb_we(o_wb_we), .O_wb_adr(o_wb_adr), .O_wb_dat(o_wb_dat),
    .I_wb_dat(wb_dat_in), .I_wb_ack(wb_ack), .I_wb_stall(wb_stall),
    .O_grant(o_grant), .O_err(o_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: owner -1 = nobody, else master index.
  int owner  = -1;
  int last_m = 1;
  int waitc  = 0;
  bit err_m  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_stb();
    return (owner == 0 && m0_stb) || (owner == 1 && m1_stb);
  endfunction

  function automatic bit m_fire();
    return TO_EN && m_stb() && !wb_ack && (waitc == LIMIT - 1);
  endfunction

  task automatic check_all();
    bit f;
    f = m_fire();
    chk("grant", o_grant, owner == 0 ? 2'b01 : owner == 1 ? 2'b10 : 2'b00);
    chk("wb_stb", o_wb_stb, m_stb());
    chk("wb_we", o_wb_we, owner == 1 ? m1_we : m0_we);
    chk("wb_adr", o_wb_adr, owner == 1 ? m1_adr : m0_adr);
    chk("wb_dat", o_wb_dat, owner == 1 ? m1_dat : m0_dat);
    chk("m0_dat", o_m0_dat, f ? 8'hFF : wb_dat_in);
    chk("m1_dat", o_m1_dat, f ? 8'hFF : wb_dat_in);
    chk("m0_ack", o_m0_ack, owner == 0 && (wb_ack || f));
    chk("m1_ack", o_m1_ack, owner == 1 && (wb_ack || f));
    chk("m0_stall", o_m0_stall, owner == 0 ? wb_stall : 1'b1);
    chk("m1_stall", o_m1_stall, owner == 1 ? wb_stall : 1'b1);
    chk("err", o_err, err_m);
  endtask

  task automatic model_edge();
    int old;
    bit stbe, f;
    if (rst) begin
      owner = -1; last_m = 1; waitc = 0; err_m = 1'b0;
    end else begin
      stbe = m_stb();
      f    = m_fire();
      old  = owner;
      if (owner < 0) begin
        if (m0_cyc && m1_cyc) owner = 1 - last_m;
        else if (m0_cyc)      owner = 0;
        else if (m1_cyc)      owner = 1;
      end else if (owner == 0 ? !m0_cyc : !m1_cyc) begin
        last_m = owner;
        owner  = (owner == 0 ? m1_cyc : m0_cyc) ? 1 - owner : -1;
      end
      if (owner != old || !stbe || wb_ack || f) waitc = 0;
      else waitc++;
      if (f) err_m = 1'b1;
    end
  endtask

  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_m0(input bit c, input bit s, input bit w, input logic [31:0] a, input logic [7:0] d);
    m0_cyc = c; m0_stb = s; m0_we = w; m0_adr = a; m0_dat = d;
  endtask

  task automatic set_m1(input bit c, input bit s, input bit w, input logic [31:0] a, input logic [7:0] d);
    m1_cyc = c; m1_stb = s; m1_we = w; m1_adr = a; m1_dat = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int first_ack;

  initial begin
    @(negedge clk);
    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst_grant", o_grant, 2'b00);
    chk("rst_stb", o_wb_stb, 1'b0);
    chk("rst_stall0", o_m0_stall, 1'b1);
    chk("rst_stall1", o_m1_stall, 1'b1);
    chk("rst_err", o_err, 1'b0);
    step();

    // Master 0 alone reads 0xFFFFF800, slave answers 0x5A after 2 wait cycles
    set_m0(1, 1, 0, 32'hFFFF_F800, 8'h00);
    step();
    chk("m0_grant_latency", o_grant, 2'b01);
    step(); step();
    wb_ack = 1; wb_dat_in = 8'h5A;
    #1;
    chk("m0_read_dat", o_m0_dat, 8'h5A);
    chk("m0_read_ack", o_m0_ack, 1'b1);
    chk("m0_read_m1ack", o_m1_ack, 1'b0);
    step();
    wb_ack = 0;
    set_m0(0, 0, 0, 32'hFFFF_F800, 8'h00);
    step(); step();

    // Simultaneous requests out of reset: m0 first, burst while m1 waits, no-bubble handover
    do_reset();
    set_m0(1, 1, 0, 32'h0000_1000, 8'h00);
    set_m1(1, 1, 1, 32'h0000_2000, 8'hA5);
    step();
    chk("contend_m0_first", o_grant, 2'b01);
    for (int i = 0; i < 3; i++) begin
      wb_ack = 1; m0_adr = 32'h0000_1000 + 32'(i);
      #1;
      chk("burst_m1_stall", o_m1_stall, 1'b1);
      chk("burst_adr", o_wb_adr, 32'h0000_1000 + 32'(i));
      step();
    end
    wb_ack = 0;
    set_m0(0, 0, 0, 32'h0, 8'h00);
    step();
    chk("handover_m1", o_grant, 2'b10);

    // m1 write 0xA5 under 4 cycles of slave stall
    wb_stall = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_follow", o_m1_stall, 1'b1);
      chk("stall_dat_hold", o_wb_dat, 8'hA5);
      step();
    end
    wb_stall = 0; wb_ack = 1;
    step();
    wb_ack = 0;
    set_m1(0, 0, 0, 32'h0, 8'h00);
    step();

    // m1 was last, so repeat contention from IDLE goes to m0
    set_m0(1, 1, 0, 32'h10, 8'h00);
    set_m1(1, 1, 0, 32'h20, 8'h00);
    step();
    chk("rr_after_m1", o_grant, 2'b01);
    set_m0(0, 0, 0, 32'h10, 8'h00);
    set_m1(0, 0, 0, 32'h20, 8'h00);
    step(); step();
    // m0 alone then contention: m1 wins
    set_m0(1, 0, 0, 32'h10, 8'h00);
    step(); step();
    set_m0(0, 0, 0, 32'h10, 8'h00);
    step();
    set_m0(1, 1, 0, 32'h10, 8'h00);
    set_m1(1, 1, 0, 32'h20, 8'h00);
    step();
    chk("rr_after_m0", o_grant, 2'b10);
    set_m0(0, 0, 0, 32'h0, 8'h00);
    set_m1(0, 0, 0, 32'h0, 8'h00);
    step(); step();

    // Slave that never acks
    set_m0(1, 1, 0, 32'h0000_0BAD, 8'h00);
    step();
    first_ack = 0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (o_m0_ack === 1'b1 && first_ack == 0) first_ack = k;
      step();
    end
    chk("timeout_cycle", first_ack, TO_EN ? LIMIT : 0);
    chk("timeout_err", o_err, TO_EN);
    set_m0(0, 0, 0, 32'h0, 8'h00);
    step(); step();
    chk("err_sticky", o_err, TO_EN);

    // Reset mid-GRANT1 with an in-flight ack
    set_m1(1, 1, 0, 32'h0000_3000, 8'h00);
    step(); step();
    wb_ack = 1; rst = 1;
    step();
    rst = 0;
    #1;
    chk("midrst_grant", o_grant, 2'b00);
    chk("midrst_stb", o_wb_stb, 1'b0);
    chk("midrst_ack1", o_m1_ack, 1'b0);
    chk("midrst_stall0", o_m0_stall, 1'b1);
    chk("midrst_stall1", o_m1_stall, 1'b1);
    chk("midrst_err", o_err, 1'b0);
    wb_ack = 0;
    set_m1(0, 0, 0, 32'h0, 8'h00);
    step();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 3) == 0) m1_cyc = ~m1_cyc;
      m0_stb = m0_cyc & $urandom_range(0, 1);
      m1_stb = m1_cyc & $urandom_range(0, 1);
      m0_we = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
      m0_adr = $urandom; m1_adr = $urandom;
      m0_dat = 8'($urandom); m1_dat = 8'($urandom); wb_dat_in = 8'($urandom);
      wb_ack = ($urandom_range(0, 5) == 0);
      wb_stall = $urandom_range(0, 1);
      rst = ($urandom_range(0, 150) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
